// File: rtl/loop_pkg.sv
// Shared definitions for the row/column loop counters and the row accumulator.
// Holds the accumulator state enum and the default loop geometry.
package loop_pkg;

  typedef enum logic {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } loop_acc_state_t;

  localparam int LOOP_IDX_W = 4;
  localparam int LOOP_ROWS  = 2;
  localparam int LOOP_COLS  = 2;

endpackage

// File: rtl/loop_idx_tracker.sv
// Mirrored row/column loop counter: column carries into row, row carry is frame end.
// Ports: clk, rst_n, adv (step once) -> exp_r, exp_c, row_end, row_last, frame_end.
module loop_idx_tracker
  import loop_pkg::*;
#(
  parameter int ROWS  = LOOP_ROWS,
  parameter int COLS  = LOOP_COLS,
  parameter int IDX_W = LOOP_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [IDX_W-1:0] exp_r,
  output logic [IDX_W-1:0] exp_c,
  output logic             row_end,
  output logic             row_last,
  output logic             frame_end
);

  localparam logic [IDX_W-1:0] R_MAX = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] C_MAX = IDX_W'(COLS - 1);

  assign row_end   = (exp_c == C_MAX);
  assign row_last  = (exp_r == R_MAX);
  assign frame_end = row_end && row_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
      exp_c <= '0;
    end else if (adv) begin
      if (row_end) begin
        exp_c <= '0;
        exp_r <= row_last ? '0 : exp_r + 1'b1;
      end else begin
        exp_c <= exp_c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/loop_row_accum.sv
// Row accumulator: checks the (r,c) stream against its own loop, sums each row,
// presents sums over valid/ready. Optional out_max via LOOP_ROW_ACCUM_MAX_EN.
// Ports: in_* element handshake, out_* row-sum handshake, err_clr/seq_err flag.
module loop_row_accum
  import loop_pkg::*;
#(
  parameter int ROWS   = LOOP_ROWS,
  parameter int COLS   = LOOP_COLS,
  parameter int IDX_W  = LOOP_IDX_W,
  parameter int DATA_W = 8,
  parameter int SUM_W  = DATA_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_r,
  input  logic [IDX_W-1:0]  in_c,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_frame_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_row,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_frame_last,
`ifdef LOOP_ROW_ACCUM_MAX_EN
  output logic [DATA_W-1:0] out_max,
`endif
  input  logic              err_clr,
  output logic              seq_err
);

  loop_acc_state_t state, state_nxt;

  logic             ready_en;
  logic [IDX_W-1:0] exp_r, exp_c;
  logic             row_end, row_last, frame_end;
  logic             accept, match, adv, row_done, err_set;
  logic [SUM_W-1:0] acc, acc_nxt;

  // ready_en keeps in_ready low until the first clock after reset release
  assign in_ready  = ready_en && !(state == PRESENT && !out_ready);
  assign accept    = in_valid && in_ready;
  assign match     = (in_r == exp_r) && (in_c == exp_c);
  assign adv       = accept && match;
  assign row_done  = adv && row_end;
  assign err_set   = accept && (!match || (in_frame_end != frame_end));
  assign acc_nxt   = acc + SUM_W'(in_data);
  assign out_valid = (state == PRESENT);

  loop_idx_tracker #(
    .ROWS (ROWS),
    .COLS (COLS),
    .IDX_W(IDX_W)
  ) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv),
    .exp_r    (exp_r),
    .exp_c    (exp_c),
    .row_end  (row_end),
    .row_last (row_last),
    .frame_end(frame_end)
  );

  // a completing row re-enters PRESENT even while the old sum is taken
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (row_done) state_nxt = PRESENT;
      PRESENT: begin
        if (row_done)       state_nxt = PRESENT;
        else if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      out_sum        <= '0;
      out_row        <= '0;
      out_frame_last <= 1'b0;
    end else if (row_done) begin
      acc            <= '0;
      out_sum        <= acc_nxt;
      out_row        <= exp_r;
      out_frame_last <= row_last;
    end else if (adv) begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       seq_err <= 1'b0;
    else if (err_set) seq_err <= 1'b1;
    else if (err_clr) seq_err <= 1'b0;
  end

`ifdef LOOP_ROW_ACCUM_MAX_EN
  logic [DATA_W-1:0] max_acc, max_nxt;

  assign max_nxt = (in_data > max_acc) ? in_data : max_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_acc <= '0;
      out_max <= '0;
    end else if (row_done) begin
      max_acc <= '0;
      out_max <= max_nxt;
    end else if (adv) begin
      max_acc <= max_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_loop_row_accum.sv
// Self-checking bench for loop_row_accum: row-level model plus literal row checks.
// Optional out_max is connected and checked when LOOP_ROW_ACCUM_MAX_EN is defined.
module tb_loop_row_accum;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_frame_end = 1'b0;
  logic              out_ready = 1'b1;
  logic              err_clr = 1'b0;
  logic [IDX_W-1:0]  in_r = '0;
  logic [IDX_W-1:0]  in_c = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid, out_frame_last, seq_err;
  logic [IDX_W-1:0]  out_row;
  logic [SUM_W-1:0]  out_sum;
`ifdef LOOP_ROW_ACCUM_MAX_EN
  logic [DATA_W-1:0] out_max;
`endif

  loop_row_accum #(
    .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W),
    .DATA_W(DATA_W), .SUM_W(SUM_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_r          (in_r),
    .in_c          (in_c),
    .in_data       (in_data),
    .in_frame_end  (in_frame_end),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .out_sum       (out_sum),
    .out_frame_last(out_frame_last),
`ifdef LOOP_ROW_ACCUM_MAX_EN
    .out_max       (out_max),
`endif
    .err_clr       (err_clr),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int sum;
    int last;
    int mx;
  } row_t;

  row_t mq[$];
  row_t taken[$];
  row_t tmp;
  int   tests = 0;
  int   fails = 0;
  int   stalls = 0;
  int   mr, mc, macc, mmax;
  bit   merr, rdy_en, pres, eset, fe_exp, hit;

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: expected indices, running row sum/max, queue of rows owed downstream
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_row", out_row, 0);
      chk("rst out_sum", out_sum, 0);
      chk("rst out_last", out_frame_last, 0);
      chk("rst seq_err", seq_err, 0);
      mq.delete();
      mr = 0; mc = 0; macc = 0; mmax = 0;
      merr = 0; rdy_en = 0;
    end else begin
      pres = (mq.size() > 0);
      chk("in_ready", in_ready, rdy_en && !(pres && !out_ready));
      chk("out_valid", out_valid, pres);
      if (pres && out_valid) begin
        chk("out_row", out_row, mq[0].row);
        chk("out_sum", out_sum, mq[0].sum);
        chk("out_last", out_frame_last, mq[0].last);
`ifdef LOOP_ROW_ACCUM_MAX_EN
        chk("out_max", out_max, mq[0].mx);
`endif
      end
      chk("seq_err", seq_err, merr);
      if (pres && out_valid && out_ready) begin
        tmp.row  = int'(out_row);
        tmp.sum  = int'(out_sum);
        tmp.last = int'(out_frame_last);
`ifdef LOOP_ROW_ACCUM_MAX_EN
        tmp.mx   = int'(out_max);
`else
        tmp.mx   = 0;
`endif
        taken.push_back(tmp);
        void'(mq.pop_front());
      end
      eset = 0;
      if (in_valid && in_ready) begin
        hit    = (int'(in_r) == mr) && (int'(in_c) == mc);
        fe_exp = (mr == ROWS - 1) && (mc == COLS - 1);
        if (!hit || (in_frame_end != fe_exp)) eset = 1;
        if (hit) begin
          macc += int'(in_data);
          if (int'(in_data) > mmax) mmax = int'(in_data);
          if (mc == COLS - 1) begin
            tmp.row  = mr;
            tmp.sum  = macc;
            tmp.last = (mr == ROWS - 1);
            tmp.mx   = mmax;
            mq.push_back(tmp);
            macc = 0; mmax = 0; mc = 0;
            mr = (mr + 1) % ROWS;
          end else begin
            mc++;
          end
        end
      end
      merr   = eset ? 1'b1 : (err_clr ? 1'b0 : merr);
      rdy_en = 1;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int r, int c, int d, bit fe);
    int n = 0;
    in_valid     = 1'b1;
    in_r         = IDX_W'(r);
    in_c         = IDX_W'(c);
    in_data      = DATA_W'(d);
    in_frame_end = fe;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send timeout: in_ready %0d after %0d cycles, required 1", in_ready, n);
    end
    stalls += n - 1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    taken.delete();
  endtask

  task automatic expect_take(string nm, int row, int sum, int last);
    if (taken.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no row, required row %0d sum %0d", nm, row, sum);
    end else begin
      tmp = taken.pop_front();
      chk({nm, " row"}, tmp.row, row);
      chk({nm, " sum"}, tmp.sum, sum);
      chk({nm, " last"}, tmp.last, last);
    end
  endtask

  initial begin
    // basic frame
    do_reset();
    send(0, 0, 3, 0);
    send(0, 1, 5, 0);
    send(1, 0, 7, 0);
    send(1, 1, 9, 1);
    idle(3);
    expect_take("basic r0", 0, 8, 0);
    expect_take("basic r1", 1, 16, 1);
    chk("basic seq_err", seq_err, 0);

    // backpressure: row 0 held while out_ready low
    do_reset();
    out_ready = 1'b0;
    send(0, 0, 3, 0);
    send(0, 1, 5, 0);
    idle(3);
    chk("hold in_ready", in_ready, 0);
    chk("hold out_valid", out_valid, 1);
    chk("hold out_sum", out_sum, 8);
    out_ready = 1'b1;
    send(1, 0, 7, 0);
    send(1, 1, 9, 1);
    idle(3);
    expect_take("bp r0", 0, 8, 0);
    expect_take("bp r1", 1, 16, 1);

    // index mismatch drops element, err_clr clears flag
    do_reset();
    send(0, 1, 4, 0);
    idle(1);
    chk("mis seq_err", seq_err, 1);
    send(0, 0, 1, 0);
    send(0, 1, 2, 0);
    idle(3);
    expect_take("mis r0", 0, 3, 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(1);
    chk("clr seq_err", seq_err, 0);

    // wrong frame_end flags error but row still sums
    do_reset();
    send(0, 0, 2, 0);
    send(0, 1, 6, 1);
    idle(3);
    expect_take("fe r0", 0, 8, 0);
    chk("fe seq_err", seq_err, 1);

    // reset mid-row discards partial sum
    do_reset();
    send(0, 0, 200, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_sum", out_sum, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(0, 0, 1, 0);
    send(0, 1, 1, 0);
    idle(3);
    expect_take("midrst r0", 0, 2, 0);

    // two back-to-back frames of 255, full throughput
    do_reset();
    stalls = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          send(r, c, 255, (r == ROWS - 1) && (c == COLS - 1));
    idle(3);
    chk("b2b stalls", stalls, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef LOOP_ROW_ACCUM_MAX_EN
      if (taken.size() > 0) chk("b2b max", taken[0].mx, 255);
`endif
      expect_take("b2b", i % 2, 510, i % 2);
    end
    chk("b2b seq_err", seq_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
